// File: rtl/noc_pkg.sv
// noc_pkg: shared flit, register-map and status-word definitions for the mesh NIC
package noc_pkg;
  localparam int FLIT_W = 64;
  localparam int VC_BIT = 63;
  localparam logic [1:0] ADDR_EJ_DATA  = 2'b00;
  localparam logic [1:0] ADDR_EJ_STAT  = 2'b01;
  localparam logic [1:0] ADDR_INJ_DATA = 2'b10;
  localparam logic [1:0] ADDR_INJ_STAT = 2'b11;
  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 4;
  function automatic logic [FLIT_W-1:0] status_word(input logic [3:0] cnt, input logic [3:0] depth);
    logic [FLIT_W-1:0] w;
    w = '0;
    w[ST_NE] = cnt != 4'd0;
    w[ST_FULL] = cnt == depth;
    w[ST_CNT_LSB +: 4] = cnt;
    return w;
  endfunction
endpackage

// File: rtl/nic_fifo.sv
// nic_fifo: small flit FIFO; pushes when full and pops when empty are ignored, dout reads 0 when empty
module nic_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage write; contents are don't-care until the count says they are valid
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap at DEPTH; full/empty are judged on pre-edge count so push+pop on a full FIFO only pops
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/mesh_nic.sv
// mesh_nic: register-mapped NIC between a processing element and a mesh router PE port
module mesh_nic
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_ro,
  input  logic                  net_si,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_ri,
  input  logic                  net_polarity
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic rd_en, inj_push, inj_pop, ej_push, ej_pop;
  logic inj_empty, inj_full, ej_empty, ej_full;
  logic [CW-1:0] inj_cnt, ej_cnt;
  logic [DATA_WIDTH-1:0] inj_dout, ej_dout, rd_val;
  assign rd_en = nicEn & ~nicWrEn;
  assign inj_push = nicEn & nicWrEn & (addr == ADDR_INJ_DATA);
  assign ej_pop = rd_en & (addr == ADDR_EJ_DATA);
  assign net_do = inj_dout;
  assign net_so = ~inj_empty & (net_polarity == inj_dout[VC_BIT]);
  assign inj_pop = net_so & net_ro;
  assign net_ri = ~ej_full;
  assign ej_push = net_si & net_ri;
  nic_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_inj (
    .clk(clk), .reset(reset), .push(inj_push), .pop(inj_pop), .din(d_in),
    .dout(inj_dout), .empty(inj_empty), .full(inj_full), .count(inj_cnt)
  );
  nic_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_ej (
    .clk(clk), .reset(reset), .push(ej_push), .pop(ej_pop), .din(net_di),
    .dout(ej_dout), .empty(ej_empty), .full(ej_full), .count(ej_cnt)
  );
  // read mux; eject data already reads 0 when the eject FIFO is empty
  always_comb
    rd_val = addr == ADDR_EJ_DATA  ? ej_dout :
             addr == ADDR_EJ_STAT  ? status_word(4'(ej_cnt), 4'(BUF_DEPTH)) :
             addr == ADDR_INJ_STAT ? status_word(4'(inj_cnt), 4'(BUF_DEPTH)) : '0;
  // d_out captures the addressed value on reads and holds otherwise
  always_ff @(posedge clk)
    if (reset) d_out <= '0;
    else if (rd_en) d_out <= rd_val;
endmodule
